// File: rtl/sim_ctrl_pkg.sv
// Shared types and defaults for the simulation-control monitor.
package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    StatNone    = 3'd0,
    StatPass    = 3'd1,
    StatFail    = 3'd2,
    StatExitOk  = 3'd3,
    StatExitErr = 3'd4,
    StatTimeout = 3'd5,
    StatStall   = 3'd6
  } sim_status_e;

  typedef enum logic [1:0] {
    StHold = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefResetWaitCycles = 4;
  localparam int unsigned DefStallCycles     = 1024;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/sim_ctrl_monitor_if.sv
// Status/control bundle between the monitor (slave) and the bench subsystem (master).
interface sim_ctrl_monitor_if #(
  parameter int unsigned NUM_CH = 1,
  parameter int unsigned CNT_W  = 32
);
  import sim_ctrl_pkg::*;

  localparam int unsigned ChW = ch_width(NUM_CH);

  logic [CNT_W-1:0]     max_cycles_i;
  logic [NUM_CH-1:0]    tests_passed_i;
  logic [NUM_CH-1:0]    tests_failed_i;
  logic [NUM_CH-1:0]    exit_valid_i;
  logic [NUM_CH*32-1:0] exit_value_i;
  logic                 progress_i;
  logic                 core_rst_no;
  logic                 fetch_enable_o;
  logic                 done_o;
  sim_status_e          status_o;
  logic [31:0]          code_o;
  logic [ChW-1:0]       channel_o;
  logic [CNT_W-1:0]     cycle_cnt_o;

  modport master (
    output max_cycles_i, tests_passed_i, tests_failed_i, exit_valid_i, exit_value_i, progress_i,
    input  core_rst_no, fetch_enable_o, done_o, status_o, code_o, channel_o, cycle_cnt_o
  );

  modport slave (
    input  max_cycles_i, tests_passed_i, tests_failed_i, exit_valid_i, exit_value_i, progress_i,
    output core_rst_no, fetch_enable_o, done_o, status_o, code_o, channel_o, cycle_cnt_o
  );

endinterface

// File: rtl/sim_ctrl_evt_arb.sv
// Combinational priority picker: lowest channel wins, then failed > exit > passed.
module sim_ctrl_evt_arb
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH = 1,
  localparam int unsigned ChW   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0]    tests_passed_i,
  input  logic [NUM_CH-1:0]    tests_failed_i,
  input  logic [NUM_CH-1:0]    exit_valid_i,
  input  logic [NUM_CH*32-1:0] exit_value_i,
  output logic                 valid_o,
  output sim_status_e          status_o,
  output logic [31:0]          code_o,
  output logic [ChW-1:0]       channel_o
);

  always_comb begin
    valid_o   = 1'b0;
    status_o  = StatNone;
    code_o    = '0;
    channel_o = '0;
    // Scan high to low so the lowest active channel is the last one written.
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (tests_failed_i[c] || exit_valid_i[c] || tests_passed_i[c]) begin
        valid_o   = 1'b1;
        channel_o = ChW'(c);
        if (tests_failed_i[c]) begin
          status_o = StatFail;
          code_o   = '0;
        end else if (exit_valid_i[c]) begin
          code_o   = exit_value_i[32*c +: 32];
          status_o = (exit_value_i[32*c +: 32] == 32'd0) ? StatExitOk : StatExitErr;
        end else begin
          status_o = StatPass;
          code_o   = '0;
        end
      end
    end
  end

endmodule

// File: rtl/sim_ctrl_monitor.sv
// Reset/fetch sequencer, cycle watchdog and first-event capture for core benches.
// Optional idle-progress stall detection is compiled in with SIM_CTRL_STALL_DETECT_EN.
module sim_ctrl_monitor
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH            = 1,
  parameter int unsigned CNT_W             = 32,
  parameter int unsigned RESET_WAIT_CYCLES = DefResetWaitCycles,
  parameter int unsigned STALL_CYCLES      = DefStallCycles
) (
  input logic              clk,
  input logic              rst_n,
  sim_ctrl_monitor_if.slave bus
);

  localparam int unsigned ChW   = ch_width(NUM_CH);
  localparam int unsigned HoldW = $clog2(RESET_WAIT_CYCLES) + 1;

  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               fetch_en_q, fetch_en_d;
  logic               done_q, done_d;
  sim_status_e        status_q, status_d;
  logic [31:0]        code_q, code_d;
  logic [ChW-1:0]     channel_q, channel_d;

  logic               arb_valid;
  sim_status_e        arb_status;
  logic [31:0]        arb_code;
  logic [ChW-1:0]     arb_channel;
  logic               stall_hit;

  sim_ctrl_evt_arb #(
    .NUM_CH (NUM_CH)
  ) u_evt_arb (
    .tests_passed_i (bus.tests_passed_i),
    .tests_failed_i (bus.tests_failed_i),
    .exit_valid_i   (bus.exit_valid_i),
    .exit_value_i   (bus.exit_value_i),
    .valid_o        (arb_valid),
    .status_o       (arb_status),
    .code_o         (arb_code),
    .channel_o      (arb_channel)
  );

`ifdef SIM_CTRL_STALL_DETECT_EN
  localparam int unsigned IdleW = $clog2(STALL_CYCLES + 1);

  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

  // Fires in the cycle the idle count would reach STALL_CYCLES.
  assign stall_hit = (state_q == StRun) && !bus.progress_i &&
                     (idle_cnt_q >= IdleW'(STALL_CYCLES - 1));

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_q == StRun) begin
      idle_cnt_d = bus.progress_i ? '0 : idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_stall;
  assign unused_stall = ^{bus.progress_i, 32'(STALL_CYCLES)};
  assign stall_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    core_rst_n_d = core_rst_n_q;
    fetch_en_d   = fetch_en_q;
    done_d       = done_q;
    status_d     = status_q;
    code_d       = code_q;
    channel_d    = channel_q;
    unique case (state_q)
      StHold: begin
        if (hold_cnt_q == HoldW'(RESET_WAIT_CYCLES - 1)) begin
          state_d      = StRun;
          core_rst_n_d = 1'b1;
          fetch_en_d   = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        if (arb_valid || stall_hit ||
            ((bus.max_cycles_i != '0) && (cycle_cnt_q >= bus.max_cycles_i))) begin
          state_d    = StDone;
          done_d     = 1'b1;
          fetch_en_d = 1'b0;
          if (arb_valid) begin
            status_d  = arb_status;
            code_d    = arb_code;
            channel_d = arb_channel;
          end else begin
            status_d  = stall_hit ? StatStall : StatTimeout;
            code_d    = 32'(cycle_cnt_q);
            channel_d = '0;
          end
        end
      end
      StDone: begin
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StHold;
      hold_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
      core_rst_n_q <= 1'b0;
      fetch_en_q   <= 1'b0;
      done_q       <= 1'b0;
      status_q     <= StatNone;
      code_q       <= '0;
      channel_q    <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      fetch_en_q   <= fetch_en_d;
      done_q       <= done_d;
      status_q     <= status_d;
      code_q       <= code_d;
      channel_q    <= channel_d;
    end
  end

  assign bus.core_rst_no    = core_rst_n_q;
  assign bus.fetch_enable_o = fetch_en_q;
  assign bus.done_o         = done_q;
  assign bus.status_o       = status_q;
  assign bus.code_o         = code_q;
  assign bus.channel_o      = channel_q;
  assign bus.cycle_cnt_o    = cycle_cnt_q;

endmodule

// File: tb/tb_sim_ctrl_monitor.sv
// Bench for sim_ctrl_monitor: directed scenarios plus random runs against a behavioural model.
module tb_sim_ctrl_monitor;
  import sim_ctrl_pkg::*;

  localparam int unsigned NumCh    = 2;
  localparam int unsigned CntW     = 32;
  localparam int unsigned RstWait  = 4;
  localparam int unsigned StallCyc = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sim_ctrl_monitor_if #(.NUM_CH(NumCh), .CNT_W(CntW)) bus_if ();

  sim_ctrl_monitor #(
    .NUM_CH            (NumCh),
    .CNT_W             (CntW),
    .RESET_WAIT_CYCLES (RstWait),
    .STALL_CYCLES      (StallCyc)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: edges since release, run/done flags, captured record.
  int          m_edges;
  bit          m_run, m_done;
  int          m_status, m_ch, m_idle;
  logic [31:0] m_code;
  longint      m_cycle;

  task automatic model_reset();
    m_edges = 0; m_run = 0; m_done = 0; m_status = 0; m_ch = 0; m_idle = 0;
    m_code = '0; m_cycle = 0;
  endtask

  // Apply the spec's rules for one posedge using the inputs currently driven.
  task automatic model_edge();
    int win;
    bit evt;
    logic [31:0] v;
    if (!rst_n || m_done) return;
    if (!m_run) begin
      m_edges++;
      if (m_edges == RstWait) m_run = 1;
      return;
    end
    win = -1;
    for (int c = 0; c < NumCh; c++) begin
      if (win < 0 && (bus_if.tests_failed_i[c] || bus_if.exit_valid_i[c] ||
                      bus_if.tests_passed_i[c])) win = c;
    end
    evt = 0;
    if (win >= 0) begin
      evt  = 1;
      m_ch = win;
      if (bus_if.tests_failed_i[win]) begin
        m_status = 2; m_code = 0;
      end else if (bus_if.exit_valid_i[win]) begin
        v = bus_if.exit_value_i[32*win +: 32];
        m_status = (v == 0) ? 3 : 4; m_code = v;
      end else begin
        m_status = 1; m_code = 0;
      end
    end
`ifdef SIM_CTRL_STALL_DETECT_EN
    else if (!bus_if.progress_i && m_idle + 1 >= StallCyc) begin
      evt = 1; m_status = 6; m_code = m_cycle[31:0]; m_ch = 0;
    end
`endif
    else if (bus_if.max_cycles_i != 0 && m_cycle >= longint'(bus_if.max_cycles_i)) begin
      evt = 1; m_status = 5; m_code = m_cycle[31:0]; m_ch = 0;
    end
    m_idle = bus_if.progress_i ? 0 : m_idle + 1;
    if (m_cycle < 64'hFFFF_FFFF) m_cycle++;
    if (evt) begin
      m_done = 1; m_run = 0;
    end
  endtask

  task automatic check_all();
    check("core_rst_no", bus_if.core_rst_no, m_run || m_done);
    check("fetch_enable", bus_if.fetch_enable_o, m_run);
    check("done", bus_if.done_o, m_done);
    check("status", bus_if.status_o, m_status);
    check("code", bus_if.code_o, m_code);
    check("channel", bus_if.channel_o, m_ch);
    check("cycle_cnt", bus_if.cycle_cnt_o, m_cycle);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic clear_strobes();
    bus_if.tests_passed_i = '0;
    bus_if.tests_failed_i = '0;
    bus_if.exit_valid_i   = '0;
    bus_if.exit_value_i   = '0;
  endtask

  // Called just after a posedge; asserts reset mid-cycle to exercise the async path.
  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("rst_done", bus_if.done_o, 1'b0);
    check("rst_core_rst", bus_if.core_rst_no, 1'b0);
    step();
  endtask

  task automatic release_seq();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= int'(RstWait); i++) begin
      step();
      check("hold_core_rst", bus_if.core_rst_no, i == int'(RstWait));
    end
    check("run_fetch", bus_if.fetch_enable_o, 1'b1);
    check("run_cnt0", bus_if.cycle_cnt_o, 0);
  endtask

  initial begin
    clear_strobes();
    bus_if.max_cycles_i = '0;
    bus_if.progress_i   = 1'b1;
    model_reset();
    #1;
    check_all();
    repeat (2) step();
    release_seq();

    // Exit on both channels: ch0 non-zero wins.
    bus_if.exit_valid_i = 2'b11;
    bus_if.exit_value_i = {32'h0, 32'h2A};
    step();
    clear_strobes();
    check("exit_done", bus_if.done_o, 1'b1);
    check("exit_status", bus_if.status_o, StatExitErr);
    check("exit_code", bus_if.code_o, 32'h2A);
    check("exit_ch", bus_if.channel_o, 0);
    bus_if.tests_passed_i = 2'b10;
    repeat (3) step();
    clear_strobes();
    check("exit_sticky", bus_if.status_o, StatExitErr);

    // ch1 fail beats ch1 pass.
    apply_reset();
    release_seq();
    bus_if.tests_failed_i = 2'b10;
    bus_if.tests_passed_i = 2'b10;
    step();
    clear_strobes();
    check("prio_status", bus_if.status_o, StatFail);
    check("prio_ch", bus_if.channel_o, 1);

    // Channel pass beats a same-cycle timeout.
    apply_reset();
    release_seq();
    bus_if.max_cycles_i = 5;
    repeat (5) step();
    check("prio_nodone", bus_if.done_o, 1'b0);
    bus_if.tests_passed_i = 2'b01;
    step();
    clear_strobes();
    check("prio_pass", bus_if.status_o, StatPass);

    // Watchdog at 100.
    apply_reset();
    release_seq();
    bus_if.max_cycles_i = 100;
    repeat (100) step();
    check("wd_pre", bus_if.done_o, 1'b0);
    step();
    check("wd_status", bus_if.status_o, StatTimeout);
    check("wd_code", bus_if.code_o, 100);
    check("wd_fetch", bus_if.fetch_enable_o, 1'b0);

    // Watchdog disabled.
    apply_reset();
    release_seq();
    bus_if.max_cycles_i = 0;
    repeat (10000) step();
    check("wd_off", bus_if.done_o, 1'b0);

    // Reset from DONE, then again mid-hold.
    bus_if.tests_passed_i = 2'b01;
    step();
    clear_strobes();
    check("mid_done", bus_if.done_o, 1'b1);
    apply_reset();
    check("mid_status", bus_if.status_o, StatNone);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();
    apply_reset();
    check("mid_hold_fetch", bus_if.fetch_enable_o, 1'b0);
    release_seq();

    // Progress pulses every 10 cycles, then stop.
    apply_reset();
    bus_if.progress_i = 1'b0;
    release_seq();
    for (int p = 0; p < 5; p++) begin
      bus_if.progress_i = 1'b1;
      step();
      bus_if.progress_i = 1'b0;
      if (p < 4) repeat (9) step();
    end
    repeat (15) step();
    check("stall_pre", bus_if.done_o, 1'b0);
    step();
`ifdef SIM_CTRL_STALL_DETECT_EN
    check("stall_done", bus_if.done_o, 1'b1);
    check("stall_status", bus_if.status_o, StatStall);
`else
    check("stall_off", bus_if.done_o, 1'b0);
`endif

    // Random runs.
    for (int run = 0; run < 40; run++) begin
      apply_reset();
      bus_if.max_cycles_i = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 200);
      release_seq();
      for (int cyc = 0; cyc < 250; cyc++) begin
        int r;
        r = $urandom_range(0, 29);
        if (r == 0) begin
          bus_if.tests_passed_i = 2'($urandom);
          bus_if.tests_failed_i = 2'($urandom);
          bus_if.exit_valid_i   = 2'($urandom);
          for (int c = 0; c < int'(NumCh); c++) begin
            bus_if.exit_value_i[32*c +: 32] = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
          end
        end else if (r > 2) begin
          clear_strobes();
        end
        if (cyc == 100 && $urandom_range(0, 1) == 1) bus_if.max_cycles_i = $urandom_range(1, 80);
        bus_if.progress_i = ($urandom_range(0, 2) != 0);
        step();
      end
      clear_strobes();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_ctrl_monitor.md
Name: sim_ctrl_monitor

Overview:
Synthesizable simulation-control block for core testbenches. It sequences core reset release and fetch enable, then watches NUM_CH independent test-status channels (pass/fail/exit). It also runs a programmable cycle watchdog and latches the first terminating event into a sticky status/code record. Benches instantiate it between the clock/reset generators and the tb subsystem(s), and end the simulation on done_o.

Parameters:
NUM_CH, 1, number of monitored status channels (1..16)
CNT_W, 32, width of cycle counter and max_cycles_i
RESET_WAIT_CYCLES, 4, clk cycles core_rst_no held low after rst_n release (>=1)
STALL_CYCLES, 1024, idle-progress limit; used only with the optional feature

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
max_cycles_i  in  CNT_W  watchdog limit; 0 = watchdog disabled; sampled every cycle
tests_passed_i  in  NUM_CH  per-channel pass strobe
tests_failed_i  in  NUM_CH  per-channel fail strobe
exit_valid_i  in  NUM_CH  per-channel exit strobe
exit_value_i  in  NUM_CH*32  per-channel exit value, channel c at [32c+31:32c]
progress_i  in  1  retire/progress pulse; ignored unless feature compiled in
core_rst_no  out  1  active-low reset to core subsystem
fetch_enable_o  out  1  fetch enable to core
done_o  out  1  sticky: terminating event captured
status_o  out  3  sim_status_e code of captured event
code_o  out  32  exit value, or cycle count for TIMEOUT/STALL
channel_o  out  max(1,$clog2(NUM_CH))  channel of captured event (0 for TIMEOUT/STALL)
cycle_cnt_o  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset (rst_n=0, async): state=HOLD, hold counter=0, core_rst_no=0, fetch_enable_o=0, done_o=0, status_o=NONE, code_o=0, channel_o=0, cycle_cnt_o=0.
- FSM states: HOLD, RUN, DONE; all outputs registered.
- HOLD: hold counter increments each clk. On the edge where it reaches RESET_WAIT_CYCLES-1, move to RUN. core_rst_no and fetch_enable_o go 1 in the same registered update, i.e. core_rst_no rises on the RESET_WAIT_CYCLES-th posedge after rst_n release.
- Channel events are ignored in HOLD.
- RUN: cycle_cnt increments every cycle; first RUN cycle shows 0. Saturates at all-ones, no wrap.
- RUN, event check each cycle, with this priority:
  1. Lowest-index channel with any strobe wins.
  2. Within that channel: failed > exit > passed.
  3. Timeout only if no channel strobe is present.
- Channel event encodings:
  - fail -> status FAIL, code 0.
  - exit -> EXIT_OK if value==0, else EXIT_ERR; code = exit value.
  - pass -> PASS, code 0.
- Timeout: max_cycles_i!=0 and cycle_cnt>=max_cycles_i -> TIMEOUT, code = cycle_cnt zero-extended/truncated to 32 bits.
- On any event: next cycle done_o=1, status/code/channel loaded, state=DONE, fetch_enable_o=0. core_rst_no stays 1 (state remains inspectable).
- DONE: terminal until rst_n. All further strobes are ignored. cycle_cnt frozen. Outputs are stable.
- Strobes are level-sampled. A strobe held for several cycles produces one capture only.
- max_cycles_i lowered below cycle_cnt mid-run -> TIMEOUT on the next RUN cycle.
- rst_n asserted in any state -> immediate return to reset values. The full hold sequence repeats on release.
- sim_status_e encoding: NONE=0, PASS=1, FAIL=2, EXIT_OK=3, EXIT_ERR=4, TIMEOUT=5, STALL=6.

Optional Feature:
Macro SIM_CTRL_STALL_DETECT_EN.
- Defined: an idle counter runs in RUN. It resets to 0 on progress_i=1, otherwise increments.
  - Reaching STALL_CYCLES -> STALL event, code=cycle_cnt, channel 0.
  - Priority is below channel strobes and above TIMEOUT.
- Undefined: no idle counter; progress_i is unused and status STALL is never produced.

Decomposition:
- Package sim_ctrl_pkg: sim_status_e enum (3-bit), state enum (HOLD/RUN/DONE), default constants for RESET_WAIT_CYCLES and STALL_CYCLES.
- One sub-module: sim_ctrl_evt_arb. It is the combinational priority picker over NUM_CH channels and returns valid, status, code and channel.
- The FSM, counters and capture registers stay in the top.

Test Plan:
- Reset sequencing: RESET_WAIT_CYCLES=4, release rst_n -> core_rst_no and fetch_enable_o rise on the 4th posedge; cycle_cnt_o=0 on the first RUN cycle.
- Exit capture: NUM_CH=2, both channels strobe exit in the same cycle, ch0 value 0x2A, ch1 value 0 -> done_o=1 next cycle, status=EXIT_ERR, code=0x2A, channel=0; later ch1 pass is ignored.
- Priority: ch1 asserts fail and pass together with no ch0 strobe -> status=FAIL, channel=1; ch0 pass plus timeout in the same cycle -> status=PASS.
- Watchdog: max_cycles_i=100, no strobes -> TIMEOUT when cycle_cnt=100, code=100, fetch_enable_o=0; max_cycles_i=0 over 10000 cycles -> no done.
- Mid-operation reset: assert rst_n in DONE and again in HOLD at count 2 -> all outputs return to reset values; the full 4-cycle hold repeats.
- With SIM_CTRL_STALL_DETECT_EN and STALL_CYCLES=16: progress_i pulses every 10 cycles then stops -> STALL exactly 16 cycles after the last pulse; without the macro, same stimulus -> no done.
